// File: rtl/sysarr_pkg.sv
// Shared types and sizing for the systolic-array tile sequencer.
//   N       : array dimension (rows per phase, output rows to drain)
//   ROW_W   : width of row_en and the row counter
//   DRAIN_W : width of the drain counter, which must be able to hold N itself
package sysarr_pkg;

  localparam int N       = 4;
  localparam int ROW_W   = (N > 1) ? $clog2(N) : 1;
  localparam int DRAIN_W = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/sysarr_row_counter.sv
// Row counter for the tile sequencer.
// Counts 0..N-1, and wraps to 0 on an enabled step while at N-1.
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   clr_i   in   synchronous clear; has priority over en_i
//   en_i    in   advance by one row
//   cnt_o   out  current row index
//   wrap_o  out  high while the counter sits at N-1
module sysarr_row_counter
  import sysarr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [ROW_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [ROW_W-1:0] cnt_q;
  logic [ROW_W-1:0] cnt_d;

  assign wrap_o = (cnt_q == ROW_W'(N - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sysarr_tile_sequencer.sv
// Sequences one tile through the systolic array control unit: N weight rows,
// then N input+partial rows under FIFO back-pressure, then waits for N output
// rows to drain before pulsing done.
//   clk, rst        clock / asynchronous active-high reset
//   start           begin a tile (only looked at in IDLE)
//   abort           return to IDLE next cycle, dropping any transfer this cycle
//   w_valid/w_ready weight row handshake
//   in_valid/in_ready input+partial row handshake
//   fifo_has_space  control-unit FIFO space, gates input streaming
//   out_row_done    one pulse per completed output row
//   weight_en, input_en, partial_en, row_en  control-unit row strobes and index
//   busy            high outside IDLE
//   done            one-cycle pulse at tile completion
module sysarr_tile_sequencer
  import sysarr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             fifo_has_space,
  input  logic             out_row_done,
  output logic             weight_en,
  output logic             input_en,
  output logic             partial_en,
  output logic [ROW_W-1:0] row_en,
  output logic             busy,
  output logic             done
);

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [ROW_W-1:0]   row_cnt;
  logic               row_wrap;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [DRAIN_W-1:0] drain_cnt_d;

  logic abort_act;
  logic w_xfer;
  logic i_xfer;
  logic drain_full;
  logic drain_last;

  // An abort in the same cycle suppresses the transfer, so no row is consumed.
  assign abort_act  = abort && (state_q != IDLE);
  assign w_xfer     = (state_q == LOAD_W) && w_valid && !abort;
  assign i_xfer     = (state_q == STREAM) && in_valid && fifo_has_space && !abort;
  assign drain_full = (drain_cnt_q == DRAIN_W'(N));
  assign drain_last = (drain_cnt_q == DRAIN_W'(N - 1)) && out_row_done;

  sysarr_row_counter u_row_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (abort_act || (state_q == IDLE)),
    .en_i   (w_xfer || i_xfer),
    .cnt_o  (row_cnt),
    .wrap_o (row_wrap)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort_act) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start)               state_d = LOAD_W;
        LOAD_W:  if (w_xfer && row_wrap)  state_d = STREAM;
        STREAM:  if (i_xfer && row_wrap)  state_d = DRAIN;
        DRAIN:   if (drain_full || drain_last) state_d = DONE;
        DONE:                             state_d = IDLE;
        default:                          state_d = IDLE;
      endcase
    end
  end

  // Drain counter also runs during STREAM so early output rows are not lost.
  always_comb begin
    drain_cnt_d = drain_cnt_q;
    if (abort_act || ((state_q == IDLE) && start)) begin
      drain_cnt_d = '0;
    end else if (((state_q == STREAM) || (state_q == DRAIN)) && out_row_done && !drain_full) begin
      drain_cnt_d = drain_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt_q <= '0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Output decode
  always_comb begin
    w_ready    = 1'b0;
    in_ready   = 1'b0;
    weight_en  = 1'b0;
    input_en   = 1'b0;
    partial_en = 1'b0;
    row_en     = '0;
    done       = 1'b0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      LOAD_W: begin
        w_ready   = !abort;
        weight_en = w_xfer;
        row_en    = row_cnt;
      end
      STREAM: begin
        in_ready   = fifo_has_space && !abort;
        input_en   = i_xfer;
        partial_en = i_xfer;
        row_en     = row_cnt;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sysarr_tile_sequencer.sv
module tb_sysarr_tile_sequencer;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       w_valid = 1'b0;
  logic       in_valid = 1'b0;
  logic       fifo_has_space = 1'b0;
  logic       out_row_done = 1'b0;
  logic       w_ready, in_ready, weight_en, input_en, partial_en, busy, done;
  logic [1:0] row_en;

  sysarr_tile_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .fifo_has_space (fifo_has_space),
    .out_row_done   (out_row_done),
    .weight_en      (weight_en),
    .input_en       (input_en),
    .partial_en     (partial_en),
    .row_en         (row_en),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a tile is described by how many weight rows, input rows
  // and drained output rows have been seen, plus whether the completion cycle
  // is in progress.
  int m_active = 0;
  int m_wrows  = 0;
  int m_irows  = 0;
  int m_drain  = 0;
  int m_fin    = 0;

  int tcyc      = 0;
  int done_seen = 0;
  int done_at   = -1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_wrows = 0; m_irows = 0; m_drain = 0; m_fin = 0;
  endtask

  function automatic bit loading();
    return m_active != 0 && m_fin == 0 && m_wrows < N;
  endfunction
  function automatic bit streaming();
    return m_active != 0 && m_fin == 0 && m_wrows == N && m_irows < N;
  endfunction
  function automatic bit draining();
    return m_active != 0 && m_fin == 0 && m_irows == N;
  endfunction

  task automatic check_outputs();
    bit ld, st;
    int exp_row;
    ld = loading();
    st = streaming();
    exp_row = ld ? m_wrows : (st ? m_irows : 0);
    check_val("w_ready",    w_ready,    ld && !abort);
    check_val("weight_en",  weight_en,  ld && w_valid && !abort);
    check_val("in_ready",   in_ready,   st && fifo_has_space && !abort);
    check_val("input_en",   input_en,   st && in_valid && fifo_has_space && !abort);
    check_val("partial_en", partial_en, st && in_valid && fifo_has_space && !abort);
    check_val("row_en",     row_en,     exp_row);
    check_val("busy",       busy,       m_active != 0);
    check_val("done",       done,       m_fin != 0);
    if (done === 1'b1) begin
      done_seen++;
      done_at = tcyc;
    end
  endtask

  task automatic model_step();
    bit ld, st, dr;
    ld = loading();
    st = streaming();
    dr = draining();
    if (abort && m_active != 0) begin
      model_reset();
    end else if (m_active == 0) begin
      if (start) begin
        m_active = 1; m_wrows = 0; m_irows = 0; m_drain = 0; m_fin = 0;
      end
    end else if (m_fin != 0) begin
      model_reset();
    end else begin
      if (ld && w_valid) m_wrows++;
      if (st && in_valid && fifo_has_space) m_irows++;
      if ((st || dr) && out_row_done && m_drain < N) m_drain++;
      if (dr && m_drain == N) m_fin = 1;
    end
  endtask

  // Entered at posedge+1: drive, check at the falling edge, step on the rising edge.
  task automatic cycle(input bit s, input bit a, input bit wv, input bit iv,
                       input bit fs, input bit od);
    start = s; abort = a; w_valid = wv; in_valid = iv;
    fifo_has_space = fs; out_row_done = od;
    #4;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
    tcyc++;
  endtask

  task automatic begin_scenario();
    tcyc = 0; done_seen = 0; done_at = -1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    idle_cycles(2);

    // Reset in the middle of STREAM, with the row counter at 2.
    begin_scenario();
    for (int c = 0; c < 7; c++) cycle(c == 0, 0, 1, 1, 1, 0);
    check_val("rst_pre_row", row_en, 2);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(4);

    // Nominal tile with drain pulses at cycles 10..13.
    begin_scenario();
    for (int c = 0; c < 17; c++) cycle(c == 0, 0, 1, 1, 1, (c >= 10 && c <= 13));
    check_val("nom_done_cnt", done_seen, 1);
    check_val("nom_done_at", done_at, 14);

    // FIFO back-pressure for 3 cycles after the second input row.
    begin_scenario();
    for (int c = 0; c < 24; c++)
      cycle(c == 0, 0, 1, 1, !(c >= 7 && c <= 9), (c >= 16 && c <= 19));
    check_val("bp_done_at", done_at, 20);

    // Weight valid toggling.
    begin_scenario();
    for (int c = 0; c < 28; c++)
      cycle(c == 0, 0, (c % 2) == 1, 1, 1, (c >= 20 && c <= 23));
    check_val("ws_done_at", done_at, 24);

    // Early drain: two pulses during STREAM, two in DRAIN, extras afterwards.
    begin_scenario();
    for (int c = 0; c < 16; c++)
      cycle(c == 0, 0, 1, 1, 1, (c == 6 || c == 7 || c == 11 || c == 12 || c == 13));
    check_val("ed_done_at", done_at, 13);
    check_val("ed_done_cnt", done_seen, 1);

    // Abort during a STREAM transfer; start while busy is ignored.
    begin_scenario();
    for (int c = 0; c < 10; c++) cycle(c <= 3, c == 6, 1, 1, 1, 0);
    check_val("ab_no_done", done_seen, 0);
    for (int c = 0; c < 16; c++) cycle(c == 0, 0, 1, 1, 1, (c >= 9 && c <= 12));
    check_val("ab_restart_done", done_seen, 1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++)
      cycle(($urandom % 100) < 30, ($urandom % 100) < 3, ($urandom % 100) < 70,
            ($urandom % 100) < 70, ($urandom % 100) < 70, ($urandom % 100) < 35);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
